// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that lets N_REQ byte producers share one UART
// transmitter. A winner's byte is latched on grant, a single tx_start is
// issued, and the arbiter then follows the transmitter's busy handshake
// (rise, then fall) before arbitrating again. If busy never rises within
// BUSY_TIMEOUT cycles the transfer is abandoned with a timeout_err pulse.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no transfer owned; grant when transmitter idle and req set
// S_START   | ack was just pulsed; issue tx_start next
// S_WAIT_HI | tx_start issued; waiting for tx_busy to rise (timed)
// S_WAIT_LO | transmitter busy with our byte; waiting for it to finish
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [8*N_REQ-1:0]         req_data,
  output logic [N_REQ-1:0]           ack,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic                       arb_busy,
  output logic [$clog2(N_REQ)-1:0]   cur_id,
  output logic                       timeout_err
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              arb_busy_q, arb_busy_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic              timeout_q, timeout_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_id;

  // Index after v, wrapping from the last requester back to 0. Works for
  // non-power-of-two N_REQ where plain ID_W overflow would not wrap.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    logic [ID_W-1:0] r;
    if (v == LAST_ID) r = '0;
    else              r = v + 1'b1;
    return r;
  endfunction

  // Scan N_REQ positions starting at p; first asserted request wins.
  // Result is {found, winner}.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [ID_W-1:0]  p);
    logic [ID_W-1:0] c;
    logic [ID_W-1:0] w;
    logic            f;
    c = p;
    w = '0;
    f = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!f && r[c]) begin
        f = 1'b1;
        w = c;
      end
      c = wrap_inc(c);
    end
    return {f, w};
  endfunction

  // Round-robin winner for the current pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    {pick_found, pick_id} = rr_pick(req, ptr_q);
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    cur_id_d   = cur_id_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A busy transmitter (e.g. driven by another master) blocks grants.
        if (!tx_busy && pick_found) begin
          state_d         = S_START;
          tx_data_d       = req_data[{pick_id, 3'b000} +: 8];
          cur_id_d        = pick_id;
          ptr_d           = wrap_inc(pick_id);
          ack_d[pick_id]  = 1'b1;
        end
      end

      S_START: begin
        tx_start_d = 1'b1;
        cnt_d      = '0;
        state_d    = S_WAIT_HI;
      end

      S_WAIT_HI: begin
        if (tx_busy) begin
          state_d = S_WAIT_LO;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LIMIT - 1'b1) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end

      S_WAIT_LO: begin
        if (!tx_busy) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    arb_busy_d = (state_d != S_IDLE);
  end

  // State and output registers; synchronous active-low reset aborts any
  // transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      arb_busy_q <= 1'b0;
      cur_id_q   <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      arb_busy_q <= arb_busy_d;
      cur_id_q   <= cur_id_d;
      timeout_q  <= timeout_d;
    end
  end

  assign ack         = ack_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign arb_busy    = arb_busy_q;
  assign cur_id      = cur_id_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=4, BUSY_TIMEOUT=16).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        arb_busy;
  logic [1:0]  cur_id;
  logic        timeout_err;

  logic        busy_man;
  logic        busy_auto;
  int          model_cnt;

  int n_chk;
  int n_err;

  int ids [5];
  int cids [5];
  int ng, nstart, seen, extra, k_to, both, nonhot;

  uart_tx_arbiter #(.N_REQ(4), .BUSY_TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .arb_busy    (arb_busy),
    .cur_id      (cur_id),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: busy for 10 cycles after each tx_start when enabled.
  assign tx_busy = busy_auto ? (model_cnt != 0) : busy_man;

  initial model_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (busy_auto && tx_start) model_cnt = 10;
    else if (model_cnt > 0)    model_cnt = model_cnt - 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completes a transfer from the tx_start cycle: busy rises, then falls.
  task automatic finish_xfer();
    busy_man = 1'b1;
    tick();
    busy_man = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    req = 4'b0000;
    req_data = 32'h44_43_42_41;
    busy_man = 1'b0;
    busy_auto = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_ack", ack, 4'b0000);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_cur_id", cur_id, 2'd0);
    chk("rst_arb_busy", arb_busy, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);

    // Single request from 0, byte 0x41
    rst_n = 1'b1;
    req = 4'b0001;
    tick();
    chk("r0_ack", ack, 4'b0001);
    chk("r0_cur_id", cur_id, 2'd0);
    chk("r0_tx_data_at_ack", tx_data, 8'h41);
    chk("r0_no_start_with_ack", tx_start, 1'b0);
    chk("r0_arb_busy", arb_busy, 1'b1);
    req = 4'b0000;
    tick();
    chk("r0_tx_start", tx_start, 1'b1);
    chk("r0_ack_cleared", ack, 4'b0000);
    chk("r0_tx_data", tx_data, 8'h41);
    busy_man = 1'b1;
    tick();
    chk("r0_start_one_cycle", tx_start, 1'b0);
    chk("r0_busy_wait_lo", arb_busy, 1'b1);
    chk("r0_data_held", tx_data, 8'h41);
    busy_man = 1'b0;
    tick();
    chk("r0_back_idle", arb_busy, 1'b0);

    // External busy blocks grant to 1 (ptr now 1)
    busy_man = 1'b1;
    req = 4'b0010;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack != 4'b0000) seen = 1;
    end
    chk("busy_no_ack", seen, 0);
    chk("busy_stays_idle", arb_busy, 1'b0);
    busy_man = 1'b0;
    tick();
    chk("busy_release_ack", ack, 4'b0010);
    chk("busy_release_id", cur_id, 2'd1);
    chk("busy_release_data", tx_data, 8'h42);
    req = 4'b0000;
    tick();
    chk("r1_tx_start", tx_start, 1'b1);
    finish_xfer();

    // Serve 0 (ptr 2 wraps to 0); pulse req[3] during WAIT_LO
    req = 4'b0001;
    tick();
    chk("wrap_ack0", ack, 4'b0001);
    req = 4'b0000;
    tick();
    busy_man = 1'b1;
    tick();
    extra = 0;
    req = 4'b1000;
    tick();
    if (ack != 4'b0000 || tx_start) extra++;
    req = 4'b0000;
    busy_man = 1'b0;
    tick();
    if (ack != 4'b0000 || tx_start) extra++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack != 4'b0000 || tx_start) extra++;
    end
    chk("pulse_ignored", extra, 0);
    chk("pulse_idle", arb_busy, 1'b0);

    // Grant to 2 then timeout with busy held low (ptr 1)
    req = 4'b0100;
    tick();
    chk("to_ack2", ack, 4'b0100);
    chk("to_cur_id", cur_id, 2'd2);
    req = 4'b0000;
    tick();
    chk("to_tx_start", tx_start, 1'b1);
    k_to = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (timeout_err && k_to == 0) begin
        k_to = k;
        break;
      end
    end
    chk("to_cycles", k_to, 16);
    chk("to_idle", arb_busy, 1'b0);
    chk("to_id_held", cur_id, 2'd2);
    tick();
    chk("to_one_cycle", timeout_err, 1'b0);
    req = 4'b1001;
    tick();
    chk("to_next_grant3", ack, 4'b1000);
    chk("to_next_id3", cur_id, 2'd3);
    chk("to_next_data", tx_data, 8'h44);
    req = 4'b0000;
    tick();
    finish_xfer();

    // Reset during WAIT_LO
    req = 4'b0100;
    tick();
    chk("rw_ack2", ack, 4'b0100);
    req = 4'b0000;
    tick();
    busy_man = 1'b1;
    tick();
    chk("rw_in_wait_lo", arb_busy, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("rw_ack", ack, 4'b0000);
    chk("rw_tx_start", tx_start, 1'b0);
    chk("rw_tx_data", tx_data, 8'h00);
    chk("rw_cur_id", cur_id, 2'd0);
    chk("rw_arb_busy", arb_busy, 1'b0);
    chk("rw_timeout", timeout_err, 1'b0);
    rst_n = 1'b1;
    busy_man = 1'b0;
    req = 4'b1010;
    tick();
    chk("rw_first_grant", ack, 4'b0010);
    chk("rw_first_id", cur_id, 2'd1);
    req = 4'b0000;
    tick();
    finish_xfer();

    // All four held, transmitter busy 10 cycles per byte
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    busy_auto = 1'b1;
    req = 4'b1111;
    ng = 0;
    nstart = 0;
    both = 0;
    nonhot = 0;
    for (int c = 0; c < 300 && ng < 5; c++) begin
      tick();
      if (tx_start) nstart++;
      if (ack != 4'b0000) begin
        if (tx_start) both = 1;
        if ($countones(ack) != 1) nonhot = 1;
        ids[ng] = -1;
        for (int j = 3; j >= 0; j--) if (ack[j]) ids[ng] = j;
        cids[ng] = int'(cur_id);
        ng++;
      end
    end
    chk("rr_grants", ng, 5);
    chk("rr_onehot", nonhot, 0);
    chk("rr_no_overlap", both, 0);
    chk("rr_starts", nstart, 4);
    chk("rr_id0", ids[0], 0);
    chk("rr_id1", ids[1], 1);
    chk("rr_id2", ids[2], 2);
    chk("rr_id3", ids[3], 3);
    chk("rr_id4", ids[4], 0);
    chk("rr_cur0", cids[0], 0);
    chk("rr_cur1", cids[1], 1);
    chk("rr_cur2", cids[2], 2);
    chk("rr_cur3", cids[3], 3);
    chk("rr_cur4", cids[4], 0);
    req = 4'b0000;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter BUSY_TIMEOUT, default 16, giving the maximum cycles to wait for tx_busy to rise after tx_start.
REQ-003 Port clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port req  input  N_REQ  per-requester transmit request, level, held until ack.
REQ-006 Port req_data  input  8*N_REQ  byte for requester i on bits [8i+7:8i], stable while req[i]=1.
REQ-007 Port ack  output  N_REQ  one-hot one-cycle pulse marking acceptance of a byte.
REQ-008 Port tx_start  output  1  one-cycle start pulse to the shared UART transmitter.
REQ-009 Port tx_data  output  8  byte presented to the transmitter.
REQ-010 Port tx_busy  input  1  transmitter busy flag.
REQ-011 Port arb_busy  output  1  high whenever the state is not IDLE.
REQ-012 Port cur_id  output  clog2(N_REQ)  index of the requester currently owning the transmitter.
REQ-013 Port timeout_err  output  1  one-cycle pulse when tx_busy fails to rise in time.

Function
REQ-014 The block SHALL implement states IDLE, START, WAIT_HI and WAIT_LO, all outputs registered.
REQ-015 In IDLE with tx_busy=0 and any req bit set, the block SHALL select the winner by round-robin starting at pointer ptr, wrapping from N_REQ-1 to 0.
REQ-016 On selection the block SHALL latch req_data of the winner into tx_data, set cur_id, set ptr to winner+1 (mod N_REQ), pulse ack[winner] for exactly one cycle and move to START.
REQ-017 In IDLE with tx_busy=1, the block SHALL not grant and SHALL remain in IDLE.
REQ-018 In START the block SHALL drive tx_start=1 for exactly one cycle, clear the timeout counter and move to WAIT_HI.
REQ-019 Latency: req sampled at edge N in IDLE -> ack high in cycle N+1 -> tx_start high in cycle N+2.
REQ-020 In WAIT_HI, tx_busy=1 SHALL move to WAIT_LO; otherwise the counter SHALL increment, and on reaching BUSY_TIMEOUT the block SHALL pulse timeout_err one cycle and return to IDLE.
REQ-021 In WAIT_LO, tx_busy=0 SHALL return the block to IDLE; no timeout applies in WAIT_LO.
REQ-022 tx_data and cur_id SHALL stay constant from the grant until the return to IDLE.
REQ-023 Exactly one tx_start SHALL be issued per ack; ack and tx_start SHALL never be high in the same cycle.
REQ-024 A req bit still high in the cycle after its ack SHALL be treated as a new request, arbitrated on the next pass through IDLE.
REQ-025 A req dropped before ack SHALL be withdrawn without side effects.
REQ-026 Fairness: a continuously asserted requester SHALL be granted within N_REQ grants.
REQ-027 Simultaneous requests SHALL yield exactly one ack bit; the others SHALL wait.

Reset
REQ-028 With rst_n=0 at a clock edge, the block SHALL enter IDLE with ptr=0, ack=0, tx_start=0, tx_data=8'h00, cur_id=0, arb_busy=0, timeout_err=0 and counter=0.
REQ-029 Reset asserted mid-transfer (any state) SHALL abort it at the next edge with no further ack or tx_start.
REQ-030 The first grant after reset SHALL go to the lowest-index asserted req.

Verification
REQ-031 Only req[0] high with req_data byte 0 = 8'h41 -> ack=4'b0001 next cycle, tx_start one cycle later with tx_data=8'h41, return to IDLE after tx_busy falls.
REQ-032 req=4'b1111 held, tx_busy model 10 cycles per byte -> ack order 0,1,2,3,0 and cur_id matching each grant.
REQ-033 Grant to requester 2, then tx_busy held 0 -> timeout_err pulse exactly 16 cycles after WAIT_HI is entered, then IDLE, next grant to 3.
REQ-034 tx_busy=1 externally while req[1]=1 in IDLE -> no ack until tx_busy=0.
REQ-035 rst_n=0 during WAIT_LO -> all outputs at reset values next cycle; the next grant goes to the lowest-index asserted req.
REQ-036 req[3] pulsed 1 cycle while arbiter is in WAIT_LO serving 0 -> no ack to 3, no extra tx_start.
